// File: rtl/traffic_phase_timer_if.sv
// Bundle of the timer's run/request inputs and its phase/timing outputs.
// The timer connects through the slave modport; whoever drives enable and
// ped_req (a controller or a bench) connects through the master modport.
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             ped_req;
  logic             ped_ack;
  logic [1:0]       phase;
  logic             advance;
  logic             tick;
  logic [CNT_W-1:0] remaining;

  modport master (
    output enable, ped_req,
    input  ped_ack, phase, advance, tick, remaining
  );

  modport slave (
    input  enable, ped_req,
    output ped_ack, phase, advance, tick, remaining
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light controller: divides clk into ticks, counts the
// dwell of each light phase and pulses advance when the phase changes. A pedestrian
// request cuts GREEN short once its minimum dwell has been served.
package traffic_light_pkg;
  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } traffic_light_t;
endpackage

module traffic_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int CLK_PER_TICK    = 1000,
  parameter int GREEN_TICKS     = 10,
  parameter int GREEN_MIN_TICKS = 3,
  parameter int YELLOW_TICKS    = 3,
  parameter int RED_TICKS       = 8,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 syn_reset,
  traffic_phase_timer_if.slave bus
);

  localparam int PCNT_W  = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0]  GREEN_DUR  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0]  YELLOW_DUR = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0]  RED_DUR    = CNT_W'(RED_TICKS);
  localparam logic [CNT_W:0]    GREEN_EXT  = (CNT_W+1)'(GREEN_TICKS);
  localparam logic [CNT_W:0]    GMIN_EXT   = (CNT_W+1)'(GREEN_MIN_TICKS);

  if (CLK_PER_TICK < 2) begin : g_bad_prescale
    $error("CLK_PER_TICK must be at least 2");
  end
  if (GREEN_TICKS < 1 || GREEN_TICKS > CNT_MAX) begin : g_bad_green
    $error("GREEN_TICKS out of range for CNT_W");
  end
  if (GREEN_MIN_TICKS < 1 || GREEN_MIN_TICKS > GREEN_TICKS) begin : g_bad_green_min
    $error("GREEN_MIN_TICKS must lie in 1..GREEN_TICKS");
  end
  if (YELLOW_TICKS < 1 || YELLOW_TICKS > CNT_MAX) begin : g_bad_yellow
    $error("YELLOW_TICKS out of range for CNT_W");
  end
  if (RED_TICKS < 1 || RED_TICKS > CNT_MAX) begin : g_bad_red
    $error("RED_TICKS out of range for CNT_W");
  end

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  traffic_light_t    phase_q, phase_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              pending_q, pending_d;
  logic              advance_q, advance_d;
  logic              ped_ack_q, ped_ack_d;

  logic              tick;
  logic              phase_legal;
  logic              expire;
  logic [CNT_W:0]    green_elapsed;
  traffic_light_t    next_phase;
  logic [CNT_W-1:0]  next_dur;

  // Tick marks the last clk of each prescaler period while running.
  assign tick = bus.enable && (pcnt_q == PCNT_LAST);

  // Next-state logic: prescaler, phase sequencing, dwell countdown and request tracking.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pcnt_d      = pcnt_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    advance_d   = 1'b0;
    ped_ack_d   = 1'b0;
    phase_legal = 1'b1;
    next_phase  = GREEN;
    next_dur    = GREEN_DUR;

    case (phase_q)
      GREEN:   begin next_phase = YELLOW; next_dur = YELLOW_DUR; end
      YELLOW:  begin next_phase = RED;    next_dur = RED_DUR;    end
      RED:     begin next_phase = GREEN;  next_dur = GREEN_DUR;  end
      default: phase_legal = 1'b0;
    endcase

    // Ticks of GREEN served once the current tick is counted; only meaningful in GREEN,
    // where remaining never exceeds GREEN_TICKS.
    green_elapsed = GREEN_EXT - {1'b0, remaining_q} + (CNT_W+1)'(1);
    expire = (remaining_q == CNT_W'(1)) ||
             ((phase_q == GREEN) && pending_q && (green_elapsed >= GMIN_EXT));

    if (bus.enable) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
      if (!phase_legal) begin
        phase_d     = GREEN;
        remaining_d = GREEN_DUR;
      end else if (tick) begin
        if (expire) begin
          phase_d     = next_phase;
          remaining_d = next_dur;
          advance_d   = 1'b1;
          ped_ack_d   = (phase_q == YELLOW) && pending_q;
        end else begin
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
    end

    // Serving a request on RED entry wins over a request seen on the same edge.
    if (ped_ack_d) begin
      pending_d = 1'b0;
    end else if (bus.ped_req) begin
      pending_d = 1'b1;
    end
  end

  // State register with synchronous reset to the start of a full GREEN phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before this edge, independent of statement order.
    if (syn_reset) begin
      pcnt_q      <= '0;
      phase_q     <= GREEN;
      remaining_q <= GREEN_DUR;
      pending_q   <= 1'b0;
      advance_q   <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      advance_q   <= advance_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.phase     = phase_q;
  assign bus.remaining = remaining_q;
  assign bus.advance   = advance_q;
  assign bus.ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: a hand-derived vector table for the free-running
// cycle, hand sequences for pedestrian, enable and reset corner cases, then random
// stimulus, all compared cycle by cycle against a dwell-time reference model.
module tb_traffic_phase_timer;
  import traffic_light_pkg::*;

  localparam int CPT = 2;
  localparam int GT  = 4;
  localparam int GM  = 2;
  localparam int YT  = 2;
  localparam int RT  = 3;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic syn_reset;
  int   total = 0;
  int   bad   = 0;

  traffic_phase_timer_if #(.CNT_W(CW)) bus ();

  traffic_phase_timer #(
    .CLK_PER_TICK   (CPT),
    .GREEN_TICKS    (GT),
    .GREEN_MIN_TICKS(GM),
    .YELLOW_TICKS   (YT),
    .RED_TICKS      (RT),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .syn_reset(syn_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: which phase we are in, how many ticks of it have elapsed,
  // and whether a pedestrian is waiting.
  traffic_light_t seq [3] = '{GREEN, YELLOW, RED};
  int dur [3] = '{GT, YT, RT};
  int m_pcnt, m_idx, m_elapsed;
  bit m_pend, m_adv, m_ack, m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic req);
    bit t, done;
    if (rst) begin
      m_pcnt = 0; m_idx = 0; m_elapsed = 0;
      m_pend = 0; m_adv = 0; m_ack = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      t = en && (m_pcnt == CPT - 1);
      m_adv = 0;
      m_ack = 0;
      if (en) m_pcnt = (m_pcnt + 1) % CPT;
      if (t) begin
        done = (m_elapsed + 1 >= dur[m_idx]) ||
               (m_idx == 0 && m_pend && m_elapsed + 1 >= GM);
        if (done) begin
          m_ack     = (m_idx == 1) && m_pend;
          m_idx     = (m_idx + 1) % 3;
          m_elapsed = 0;
          m_adv     = 1;
        end else begin
          m_elapsed++;
        end
      end
      if (m_ack) m_pend = 0;
      else if (req) m_pend = 1;
    end
  endtask

  // One clock: check tick before the edge, advance the model, check registered outputs after.
  task automatic step();
    logic rst, en, req;
    #1;
    rst = syn_reset;
    en  = bus.enable;
    req = bus.ped_req;
    if (m_valid) check("tick", bus.tick, en && (m_pcnt == CPT - 1));
    @(posedge clk);
    model_edge(rst, en, req);
    #1;
    if (m_valid) begin
      check("phase", bus.phase, seq[m_idx]);
      check("remaining", bus.remaining, dur[m_idx] - m_elapsed);
      check("advance", bus.advance, m_adv);
      check("ped_ack", bus.ped_ack, m_ack);
    end
  endtask

  // Steps until the phase changes; n is the number of cycles taken.
  task automatic measure(input string name, output int n);
    logic [1:0] p0;
    p0 = bus.phase;
    n  = 0;
    do begin
      step();
      n++;
    end while (bus.phase == p0 && n < 200);
    if (bus.phase == p0) begin
      total++;
      bad++;
      $display("FAIL %s: phase stuck at %0d after %0d cycles", name, p0, n);
    end
  endtask

  typedef struct {
    logic           en;
    logic           req;
    logic           tick;
    traffic_light_t ph;
    int             rem;
    logic           adv;
    logic           ack;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n, acks, guard;

    // Free-running cycle from reset: tick every 2nd clk, GREEN 8, YELLOW 4, RED 6 clks.
    tbl[0]  = '{1, 0, 0, GREEN,  4, 0, 0};
    tbl[1]  = '{1, 0, 1, GREEN,  3, 0, 0};
    tbl[2]  = '{1, 0, 0, GREEN,  3, 0, 0};
    tbl[3]  = '{1, 0, 1, GREEN,  2, 0, 0};
    tbl[4]  = '{1, 0, 0, GREEN,  2, 0, 0};
    tbl[5]  = '{1, 0, 1, GREEN,  1, 0, 0};
    tbl[6]  = '{1, 0, 0, GREEN,  1, 0, 0};
    tbl[7]  = '{1, 0, 1, YELLOW, 2, 1, 0};
    tbl[8]  = '{1, 0, 0, YELLOW, 2, 0, 0};
    tbl[9]  = '{1, 0, 1, YELLOW, 1, 0, 0};
    tbl[10] = '{1, 0, 0, YELLOW, 1, 0, 0};
    tbl[11] = '{1, 0, 1, RED,    3, 1, 0};
    tbl[12] = '{1, 0, 0, RED,    3, 0, 0};
    tbl[13] = '{1, 0, 1, RED,    2, 0, 0};
    tbl[14] = '{1, 0, 0, RED,    2, 0, 0};
    tbl[15] = '{1, 0, 1, RED,    1, 0, 0};
    tbl[16] = '{1, 0, 0, RED,    1, 0, 0};
    tbl[17] = '{1, 0, 1, GREEN,  4, 1, 0};

    syn_reset   = 1'b1;
    bus.enable  = 1'b1;
    bus.ped_req = 1'b0;
    step();
    step();
    syn_reset = 1'b0;
    check("rst_phase", bus.phase, GREEN);
    check("rst_remaining", bus.remaining, GT);
    check("rst_advance", bus.advance, 1'b0);
    check("rst_ped_ack", bus.ped_ack, 1'b0);
    check("rst_tick", bus.tick, 1'b0);

    for (int k = 0; k < 18; k++) begin
      bus.enable  = tbl[k].en;
      bus.ped_req = tbl[k].req;
      #1;
      check($sformatf("tbl%0d_tick", k), bus.tick, tbl[k].tick);
      step();
      check($sformatf("tbl%0d_phase", k), bus.phase, tbl[k].ph);
      check($sformatf("tbl%0d_remaining", k), bus.remaining, tbl[k].rem);
      check($sformatf("tbl%0d_advance", k), bus.advance, tbl[k].adv);
      check($sformatf("tbl%0d_ped_ack", k), bus.ped_ack, tbl[k].ack);
    end

    // Request at GREEN entry: GREEN cut to 2 ticks, ack on RED entry, next GREEN full.
    bus.ped_req = 1'b1;
    measure("s2_green", n);
    check("s2_green_len", n, 4);
    measure("s2_yellow", n);
    check("s2_yellow_len", n, 4);
    check("s2_ack", bus.ped_ack, 1'b1);
    bus.ped_req = 1'b0;
    step();
    check("s2_ack_one_cycle", bus.ped_ack, 1'b0);
    measure("s2_red", n);
    check("s2_red_rest", n, 5);
    measure("s2_green_full", n);
    check("s2_green_full_len", n, 8);

    // One-cycle request mid-RED: RED unchanged, following GREEN short, ack later.
    measure("s3_yellow", n);
    step();
    step();
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    measure("s3_red", n);
    check("s3_red_rest", n, 3);
    measure("s3_green", n);
    check("s3_green_short", n, 4);
    measure("s3_yellow2", n);
    check("s3_ack", bus.ped_ack, 1'b1);

    // Freeze mid-GREEN with remaining=3, then finish the phase exactly.
    measure("s4_red", n);
    step();
    step();
    check("s4_rem_before", bus.remaining, 3);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("s4_frozen_tick", bus.tick, 1'b0);
      check("s4_frozen_rem", bus.remaining, 3);
      check("s4_frozen_phase", bus.phase, GREEN);
    end
    bus.enable = 1'b1;
    measure("s4_green", n);
    check("s4_green_rest", n, 6);

    // Reset mid-YELLOW with a pending request: the request is dropped, never acked.
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    step();
    syn_reset = 1'b1;
    step();
    syn_reset = 1'b0;
    check("s5_phase", bus.phase, GREEN);
    check("s5_remaining", bus.remaining, GT);
    measure("s5_green", n);
    check("s5_green_full", n, 8);
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.ped_ack) acks++;
    end
    check("s5_no_ack", acks, 0);

    // Request held through the ack re-arms and truncates the next GREEN too.
    guard = 0;
    while (!(bus.phase == GREEN && bus.advance) && guard < 100) begin
      step();
      guard++;
    end
    check("s6_found_green_entry", bus.phase == GREEN && bus.advance, 1'b1);
    bus.ped_req = 1'b1;
    measure("s6_green", n);
    check("s6_green_short", n, 4);
    measure("s6_yellow", n);
    check("s6_ack", bus.ped_ack, 1'b1);
    step();
    measure("s6_red", n);
    check("s6_red_rest", n, 5);
    measure("s6_green2", n);
    check("s6_green_trunc", n, 4);
    bus.ped_req = 1'b0;

    // Random enable, request and occasional reset against the model.
    for (int i = 0; i < 3000; i++) begin
      syn_reset  = ($urandom_range(0, 299) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      if (bus.ped_ack) bus.ped_req = 1'b0;
      else if ($urandom_range(0, 19) == 0) bus.ped_req = ~bus.ped_req;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
